// File: rtl/rv_div_seq.sv
// rv_div_seq: multi-cycle RISC-V M-extension divider (DIV, DIVU, REM, REMU).
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle,
// followed by a sign-fix cycle. The result is held until the consumer takes it.
module rv_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  input  logic            result_ready
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [CW-1:0]   LAST_IT  = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;          // partial remainder
  logic [XLEN-1:0] quo_q, quo_d;          // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0] dvs_q, dvs_d;          // divisor magnitude
  logic            sel_rem_q, sel_rem_d;  // op[1]: return remainder instead of quotient
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            result_valid_q, result_valid_d;

  logic            signed_op;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  assign start_ready  = (state_q == IDLE) && !rst;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

  // Operand magnitudes and the 33-bit trial subtraction of one CALC iteration.
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
    b_mag     = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
    shifted   = {rem_q, quo_q[XLEN-1]};
    trial     = shifted - {1'b0, dvs_q};
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    dvs_d          = dvs_q;
    sel_rem_d      = sel_rem_q;
    quo_neg_d      = quo_neg_q;
    rem_neg_d      = rem_neg_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid && !flush) begin
          sel_rem_d = op[1];
          quo_neg_d = signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
          rem_neg_d = signed_op && dividend[XLEN-1];
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          if (divisor == '0) begin
            result_d       = op[1] ? dividend : ALL_ONES;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else if (signed_op && dividend == INT_MIN && divisor == ALL_ONES) begin
            result_d       = op[1] ? '0 : INT_MIN;
            result_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) begin
          state_d = FIX;
        end
      end

      FIX: begin
        result_d       = sel_rem_q ? (rem_neg_q ? -rem_q : rem_q)
                                   : (quo_neg_q ? -quo_q : quo_q);
        result_valid_d = 1'b1;
        state_d        = DONE;
      end

      DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A flush kills whatever is in flight, including a pending result.
    if (flush) begin
      state_d        = IDLE;
      result_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too; they are few, and it keeps
      // a reset mid-operation from leaving stale operands behind.
      state_q        <= IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      sel_rem_q      <= 1'b0;
      quo_neg_q      <= 1'b0;
      rem_neg_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      dvs_q          <= dvs_d;
      sel_rem_q      <= sel_rem_d;
      quo_neg_q      <= quo_neg_d;
      rem_neg_q      <= rem_neg_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule

// File: tb/tb_rv_div_seq.sv
// Directed testbench for rv_div_seq: hand-computed results, latency, handshake,
// backpressure, flush and reset behaviour.
module tb_rv_div_seq;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  int n_checks = 0;
  int n_pass   = 0;

  rv_div_seq #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one op from a falling edge with the unit idle, then wait for the
  // result. exp_edge is the edge index (accept = 0) after which result_valid
  // must first be seen. With result_ready high, also checks the idle cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_edge);
    int edge_n;
    bit busy_bad;
    check({tag, " start_ready"}, {31'b0, start_ready}, 32'd1);
    start_valid = 1'b1;
    op          = o;
    dividend    = a;
    divisor     = b;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op          = ~o;
    dividend    = ~a;
    divisor     = b + 32'd5;
    edge_n      = 0;
    busy_bad    = 1'b0;
    @(negedge clk);
    while (!result_valid && edge_n < 100) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk);
      edge_n++;
      @(negedge clk);
    end
    check({tag, " latency"}, edge_n, exp_edge);
    check({tag, " result"}, result, exp);
    check({tag, " busy_during"}, {31'b0, busy_bad | ~busy}, 32'd0);
    if (result_ready) begin
      @(negedge clk);
      check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
      check({tag, " idle_valid"}, {31'b0, result_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start_valid  = 1'b0;
    op           = OP_DIV;
    dividend     = '0;
    divisor      = '0;
    flush        = 1'b0;
    result_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset start_ready", {31'b0, start_ready}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset valid", {31'b0, result_valid}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back general ops with result_ready tied high.
    run_op("div 10/3",       OP_DIV,  32'd10,        32'd3,         32'd3,         33);
    run_op("rem -10/3",      OP_REM,  -32'sd10,      32'd3,         32'hFFFF_FFFF, 33);
    run_op("divu ffff/2",    OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 33);
    run_op("div -10/-3",     OP_DIV,  -32'sd10,      -32'sd3,       32'd3,         33);
    run_op("rem 10/-3",      OP_REM,  32'd10,        -32'sd3,       32'd1,         33);
    run_op("div 0/3",        OP_DIV,  32'd0,         32'd3,         32'd0,         33);
    run_op("divu 7/7",       OP_DIVU, 32'd7,         32'd7,         32'd1,         33);
    run_op("div -7/2",       OP_DIV,  -32'sd7,       32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem -7/2",       OP_REM,  -32'sd7,       32'd2,         32'hFFFF_FFFF, 33);
    run_op("remu ffff/16",   OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        33);
    run_op("remu 100/7",     OP_REMU, 32'd100,       32'd7,         32'd2,         33);

    // Divide by zero and signed overflow resolve at the accept edge.
    run_op("div 7/0",        OP_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF, 0);
    run_op("rem 7/0",        OP_REM,  32'd7,         32'd0,         32'd7,         0);
    run_op("divu min/0",     OP_DIVU, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 0);
    run_op("div ovf",        OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem ovf",        OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    run_op("divu min/ffff",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

    // Backpressure: DONE holds while result_ready is low, no new accept.
    result_ready = 1'b0;
    run_op("bp div 100/7", OP_DIV, 32'd100, 32'd7, 32'd14, 33);
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'b1;
      op          = OP_DIVU;
      dividend    = 32'd5;
      divisor     = 32'd1;
      @(posedge clk);
      @(negedge clk);
      check("bp result", result, 32'd14);
      check("bp valid", {31'b0, result_valid}, 32'd1);
      check("bp start_ready", {31'b0, start_ready}, 32'd0);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    check("bp consume busy", {31'b0, busy}, 32'd0);
    check("bp consume valid", {31'b0, result_valid}, 32'd0);
    run_op("after bp divu 9/2", OP_DIVU, 32'd9, 32'd2, 32'd4, 33);

    // Flush at CALC iteration 15.
    start_valid = 1'b1;
    op          = OP_DIV;
    dividend    = 32'h7FFF_FFFF;
    divisor     = 32'd3;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush valid", {31'b0, result_valid}, 32'd0);
    check("flush start_ready", {31'b0, start_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("flush no result", {31'b0, result_valid | busy}, 32'd0);
    run_op("post flush div 100/7", OP_DIV, 32'd100, 32'd7, 32'd14, 33);

    // start_valid with flush in the same cycle is not accepted.
    start_valid = 1'b1;
    flush       = 1'b1;
    op          = OP_DIV;
    dividend    = 32'd10;
    divisor     = 32'd3;
    @(negedge clk);
    start_valid = 1'b0;
    flush       = 1'b0;
    check("flush+start busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("flush+start valid", {31'b0, result_valid | busy}, 32'd0);

    // Flush in DONE together with result_ready.
    result_ready = 1'b0;
    run_op("done flush div 7/0", OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
    flush        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("done flush busy", {31'b0, busy}, 32'd0);
    check("done flush valid", {31'b0, result_valid}, 32'd0);
    @(negedge clk);
    check("done flush stays idle", {31'b0, result_valid | busy}, 32'd0);

    // Reset pulse mid-CALC; result register still holds 0xFFFFFFFF beforehand.
    start_valid = 1'b1;
    op          = OP_DIV;
    dividend    = 32'd100;
    divisor     = 32'd7;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst start_ready", {31'b0, start_ready}, 32'd0);
    check("rst valid", {31'b0, result_valid}, 32'd0);
    check("rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst start_ready", {31'b0, start_ready}, 32'd1);
    run_op("post rst divu 7/7", OP_DIVU, 32'd7, 32'd7, 32'd1, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
